// File: rtl/kgp_mul_pkg.sv
// Shared definitions for the multiply sequencer.
//   mul_state_e            : sequencer state encoding (IDLE, SETTLE, CAPTURE, WB)
//   SETTLE_CYCLES_DEFAULT  : default operand settle time in clocks
//   RD_W                   : destination register index width
//   CNT_W                  : settle counter width (covers 1..15 settle cycles)
package kgp_mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WB      = 2'd3
  } mul_state_e;

  localparam int SETTLE_CYCLES_DEFAULT = 3;
  localparam int RD_W                  = 5;
  localparam int CNT_W                 = 4;

endpackage

// File: rtl/mul_settle_counter.sv
// Loadable up-counter with a terminal flag, used to time operand settling.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : load load_val (takes priority over inc)
//   load_val  : value to load
//   inc       : increment by one
//   terminal  : count currently equals TERM_VAL
module mul_settle_counter
  import kgp_mul_pkg::*;
#(
  parameter int TERM_VAL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic             terminal
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(TERM_VAL);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (inc) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == TERM);

endmodule

// File: rtl/mul_sequencer.sv
// Multiply sequencer: latches a request, holds the operands stable on mul_a/mul_b
// for SETTLE_CYCLES+1 clocks (multicycle path into an external combinational
// multiplier), captures {mul_hi, mul_lo}, then presents LO for writeback.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/req_ready   : request handshake; req_a, req_b operands, req_rd index
//   mul_a, mul_b          : latched operands to the multiplier
//   mul_lo, mul_hi        : product halves from the multiplier
//   wb_valid/wb_ready     : writeback handshake; wb_data = LO, wb_rd = index
//   busy                  : sequencer is not in IDLE
// Optional feature, macro MUL_HILO_READ_EN: adds hilo_rd_en, hilo_sel (0=LO,1=HI)
// and a registered hilo_rd_data read port; HI is only stored in that build.
// Handshakes: a transfer happens on a clock edge where valid && ready are both
// high; the sender holds its payload stable while valid && !ready.
module mul_sequencer
  import kgp_mul_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
  parameter int WIDTH         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [RD_W-1:0]  req_rd,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_lo,
  input  logic [WIDTH-1:0] mul_hi,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [RD_W-1:0]  wb_rd,
  output logic [WIDTH-1:0] wb_data,
`ifdef MUL_HILO_READ_EN
  input  logic             hilo_rd_en,
  input  logic             hilo_sel,
  output logic [WIDTH-1:0] hilo_rd_data,
`endif
  output logic             busy
);

  mul_state_e state_q, state_d;
  logic req_ready_q, busy_q, wb_valid_q;
  logic accept, capture, cnt_term;

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, lo_q, lo_d;
  logic [RD_W-1:0]  rd_q, rd_d;

  assign accept  = req_valid && (state_q == ST_IDLE);
  assign capture = (state_q == ST_CAPTURE);

  // Counter is cleared on the acceptance edge, so the first SETTLE cycle sees 0.
  mul_settle_counter #(
    .TERM_VAL (SETTLE_CYCLES - 1)
  ) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val ('0),
    .inc      (state_q == ST_SETTLE),
    .terminal (cnt_term)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept)   state_d = ST_SETTLE;
      ST_SETTLE:  if (cnt_term) state_d = ST_CAPTURE;
      ST_CAPTURE:               state_d = ST_WB;
      ST_WB:      if (wb_ready) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
      wb_valid_q  <= (state_d == ST_WB);
    end
  end

  always_comb begin
    a_d  = accept  ? req_a  : a_q;
    b_d  = accept  ? req_b  : b_q;
    rd_d = accept  ? req_rd : rd_q;
    lo_d = capture ? mul_lo : lo_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      rd_q <= '0;
      lo_q <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      rd_q <= rd_d;
      lo_q <= lo_d;
    end
  end

`ifdef MUL_HILO_READ_EN
  logic [WIDTH-1:0] hi_q, hi_d, rd_data_q, rd_data_d;

  // Reads use the pre-capture register values, so a read in the CAPTURE
  // cycle returns the old product half.
  always_comb begin
    hi_d      = capture ? mul_hi : hi_q;
    rd_data_d = rd_data_q;
    if (hilo_rd_en) begin
      rd_data_d = hilo_sel ? hi_q : lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q      <= '0;
      rd_data_q <= '0;
    end else begin
      hi_q      <= hi_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign hilo_rd_data = rd_data_q;
`else
  // HI is not stored in this build; the input is intentionally left unused.
  logic mul_hi_unused;
  assign mul_hi_unused = ^mul_hi;
`endif

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign wb_valid  = wb_valid_q;
  assign mul_a     = a_q;
  assign mul_b     = b_q;
  assign wb_data   = lo_q;
  assign wb_rd     = rd_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer (WIDTH=32, SETTLE_CYCLES=3) with a stub signed
// multiplier. HI checks need MUL_HILO_READ_EN defined.
module tb_mul_sequencer;

  localparam int W   = 32;
  localparam int S   = 3;
  localparam int LAT = S + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, wb_valid, wb_ready, busy;
  logic [W-1:0]  req_a, req_b, mul_a, mul_b, mul_lo, mul_hi, wb_data;
  logic [4:0]    req_rd, wb_rd;
`ifdef MUL_HILO_READ_EN
  logic          hilo_rd_en, hilo_sel;
  logic [W-1:0]  hilo_rd_data;
`endif

  // Stub combinational multiplier: full signed product.
  logic signed [2*W-1:0] prod;
  assign prod   = $signed(mul_a) * $signed(mul_b);
  assign mul_lo = prod[W-1:0];
  assign mul_hi = prod[2*W-1:W];

  mul_sequencer #(.SETTLE_CYCLES(S), .WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_rd       (req_rd),
    .mul_a        (mul_a),
    .mul_b        (mul_b),
    .mul_lo       (mul_lo),
    .mul_hi       (mul_hi),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
`ifdef MUL_HILO_READ_EN
    .hilo_rd_en   (hilo_rd_en),
    .hilo_sel     (hilo_sel),
    .hilo_rd_data (hilo_rd_data),
`endif
    .busy         (busy)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef MUL_HILO_READ_EN
  task automatic check_hi(input string name, input logic [W-1:0] exp);
    hilo_rd_en = 1'b1;
    hilo_sel   = 1'b1;
    tick();
    hilo_rd_en = 1'b0;
    check(name, hilo_rd_data, exp);
  endtask
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   rd;
    logic [W-1:0] exp_lo;
    logic [W-1:0] exp_hi;
  } vec_t;

  vec_t vecs[6];

  // ---------------- driver ----------------
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int bad;
    req_a = v.a; req_b = v.b; req_rd = v.rd; req_valid = 1'b1;
    check($sformatf("v%0d_req_ready", idx), req_ready, 1);
    tick();
    // Disturb the request inputs while settling; mul_a/mul_b must not follow.
    req_valid = 1'b0; req_a = ~v.a; req_b = ~v.b; req_rd = ~v.rd;
    lat = 1; bad = 0;
    while (!wb_valid && lat < 20) begin
      if (mul_a !== v.a || mul_b !== v.b) bad++;
      tick();
      lat++;
    end
    check($sformatf("v%0d_latency", idx), lat, LAT);
    check($sformatf("v%0d_operands_stable", idx), bad, 0);
    check($sformatf("v%0d_wb_data", idx), wb_data, v.exp_lo);
    check($sformatf("v%0d_wb_rd", idx), wb_rd, v.rd);
    check($sformatf("v%0d_busy", idx), busy, 1);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check($sformatf("v%0d_wb_valid_drop", idx), wb_valid, 0);
`ifdef MUL_HILO_READ_EN
    check_hi($sformatf("v%0d_hi", idx), v.exp_hi);
`endif
  endtask

  // ---------------- test ----------------
  initial begin
    int lat;
    int bad;
    int pulses;
    int nacc, nwb;
    logic acc;
    int acc_t[2];
    int wb_t[2];
    logic [W-1:0] wb_d[2];
    logic [4:0]   wb_r[2];

    vecs[0] = '{32'd6,        32'd7,        5'd3,  32'd42,       32'd0};
    vecs[1] = '{32'hFFFFFFFF, 32'd2,        5'd7,  32'hFFFFFFFE, 32'hFFFFFFFF};
    vecs[2] = '{32'h80000000, 32'h80000000, 5'd31, 32'h00000000, 32'h40000000};
    vecs[3] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 5'd1,  32'h00000001, 32'h3FFFFFFF};
    vecs[4] = '{32'hFFFFFFFD, 32'd5,        5'd0,  32'hFFFFFFF1, 32'hFFFFFFFF};
    vecs[5] = '{32'h12345678, 32'd0,        5'd16, 32'h00000000, 32'h00000000};

    rst = 1'b1; req_valid = 1'b0; wb_ready = 1'b0;
    req_a = '0; req_b = '0; req_rd = '0;
`ifdef MUL_HILO_READ_EN
    hilo_rd_en = 1'b0; hilo_sel = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_req_ready", req_ready, 1);
    check("rst_busy",      busy,      0);
    check("rst_wb_valid",  wb_valid,  0);
    check("rst_mul_a",     mul_a,     0);
    check("rst_mul_b",     mul_b,     0);
    check("rst_wb_data",   wb_data,   0);
    check("rst_wb_rd",     wb_rd,     0);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Writeback stall with an ignored request pulse
    req_a = 32'd6; req_b = 32'd7; req_rd = 5'd9; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!wb_valid && lat < 20) begin tick(); lat++; end
    check("stall_latency", lat, LAT);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (wb_valid !== 1'b1 || wb_data !== 32'd42 || wb_rd !== 5'd9 ||
          busy !== 1'b1 || req_ready !== 1'b0) bad++;
      if (i == 1) begin
        req_valid = 1'b1; req_a = 32'd100; req_b = 32'd3; req_rd = 5'd1;
      end else begin
        req_valid = 1'b0;
      end
      tick();
    end
    check("stall_outputs_stable", bad, 0);
    check("stall_still_valid", wb_valid, 1);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy !== 1'b0 || req_ready !== 1'b1) bad++;
      tick();
    end
    check("stall_pulse_ignored", bad, 0);
    check("stall_lo_holds", wb_data, 32'd42);

    // Reset in the first SETTLE cycle
    req_a = 32'h12345678; req_b = 32'h10; req_rd = 5'd12; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("mid_rst_busy_before", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_busy",      busy,      0);
    check("mid_rst_mul_a",     mul_a,     0);
    check("mid_rst_mul_b",     mul_b,     0);
    check("mid_rst_wb_data",   wb_data,   0);
    check("mid_rst_wb_rd",     wb_rd,     0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (wb_valid !== 1'b0) pulses++;
      tick();
    end
    check("mid_rst_no_wb_valid", pulses, 0);
`ifdef MUL_HILO_READ_EN
    check_hi("mid_rst_hi", 32'd0);
`endif

    // Back-to-back requests with req_valid held high
    req_a = 32'd6; req_b = 32'd7; req_rd = 5'd4; req_valid = 1'b1; wb_ready = 1'b1;
    nacc = 0; nwb = 0;
    acc_t = '{0, 0}; wb_t = '{0, 0}; wb_d = '{'0, '0}; wb_r = '{'0, '0};
    for (int t = 0; t < 40 && nwb < 2; t++) begin
      acc = req_valid && req_ready;
      if (wb_valid && wb_ready) begin
        wb_t[nwb] = t; wb_d[nwb] = wb_data; wb_r[nwb] = wb_rd; nwb++;
      end
      if (acc && nacc < 2) begin acc_t[nacc] = t; nacc++; end
      tick();
      if (acc && nacc == 1) begin req_a = 32'h80000000; req_b = 32'd2; req_rd = 5'd5; end
      if (acc && nacc == 2) req_valid = 1'b0;
    end
    wb_ready = 1'b0;
    req_valid = 1'b0;
    check("b2b_accepts",     nacc, 2);
    check("b2b_writebacks",  nwb,  2);
    check("b2b_lat0",        wb_t[0] - acc_t[0], LAT);
    check("b2b_gap",         acc_t[1] - wb_t[0], 1);
    check("b2b_lat1",        wb_t[1] - acc_t[1], LAT);
    check("b2b_data0",       wb_d[0], 32'd42);
    check("b2b_rd0",         wb_r[0], 5'd4);
    check("b2b_data1",       wb_d[1], 32'd0);
    check("b2b_rd1",         wb_r[1], 5'd5);
`ifdef MUL_HILO_READ_EN
    check_hi("b2b_hi", 32'hFFFFFFFF);

    // Read in the CAPTURE cycle returns the old HI, the next read the new one
    req_a = 32'd6; req_b = 32'd7; req_rd = 5'd2; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (lat < S + 1) begin tick(); lat++; end
    hilo_rd_en = 1'b1; hilo_sel = 1'b1;
    tick();
    check("rdport_old_hi", hilo_rd_data, 32'hFFFFFFFF);
    tick();
    check("rdport_new_hi", hilo_rd_data, 32'd0);
    hilo_rd_en = 1'b0; hilo_sel = 1'b0;
    tick();
    check("rdport_hold", hilo_rd_data, 32'd0);
    hilo_rd_en = 1'b1;
    tick();
    hilo_rd_en = 1'b0;
    check("rdport_lo", hilo_rd_data, 32'd42);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check("rdport_wb_done", busy, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
